// File: rtl/mul_div_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mul_div_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Operation select as presented on Op
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_CALC  = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/mul_div_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign restore.
module mul_div_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   // Negate when requested, otherwise pass through
   assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair over WIDTH calculation cycles.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             DivByZero
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ACC_W = 2 * WIDTH + 1;

   state_e               state_q;
   op_e                  op_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [ACC_W-1:0]     acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 neg_a_q;
   logic                 neg_b_q;
   logic                 busy_q;
   logic                 done_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 dbz_q;

   logic                 is_div_c;
   logic                 is_sgn_c;
   logic [WIDTH-1:0]     mag_a_c;
   logic [WIDTH-1:0]     mag_b_c;
   logic [WIDTH-1:0]     addend_c;
   logic [WIDTH:0]       mul_sum_c;
   logic [ACC_W-1:0]     mul_step_c;
   logic [ACC_W-1:0]     div_shl_c;
   logic [WIDTH:0]       div_trial_c;
   logic [ACC_W-1:0]     div_step_c;
   logic [2*WIDTH-1:0]   prod_fix_c;
   logic [WIDTH-1:0]     quo_fix_c;
   logic [WIDTH-1:0]     rem_fix_c;

   assign is_div_c = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign is_sgn_c = (op_q == OP_MULT) || (op_q == OP_DIV);

   // Operand magnitudes for signed ops
   mul_div_sign_fix #(.W(WIDTH)) u_abs_a (
      .val_i (a_q),
      .neg_i (is_sgn_c & a_q[WIDTH-1]),
      .res_o (mag_a_c)
   );

   mul_div_sign_fix #(.W(WIDTH)) u_abs_b (
      .val_i (b_q),
      .neg_i (is_sgn_c & b_q[WIDTH-1]),
      .res_o (mag_b_c)
   );

   // Result sign restore: product/quotient follow sign mismatch, remainder follows dividend
   mul_div_sign_fix #(.W(2 * WIDTH)) u_fix_prod (
      .val_i (acc_q[2*WIDTH-1:0]),
      .neg_i (neg_a_q ^ neg_b_q),
      .res_o (prod_fix_c)
   );

   mul_div_sign_fix #(.W(WIDTH)) u_fix_quo (
      .val_i (acc_q[WIDTH-1:0]),
      .neg_i (neg_a_q ^ neg_b_q),
      .res_o (quo_fix_c)
   );

   mul_div_sign_fix #(.W(WIDTH)) u_fix_rem (
      .val_i (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i (neg_a_q),
      .res_o (rem_fix_c)
   );

   // Shift-add step: add multiplicand to the upper half when the low multiplier bit is set, then shift right
   assign addend_c   = acc_q[0] ? b_q : {WIDTH{1'b0}};
   assign mul_sum_c  = acc_q[2*WIDTH:WIDTH] + {1'b0, addend_c};
   assign mul_step_c = {1'b0, mul_sum_c, acc_q[WIDTH-1:1]};

   // Restoring division step: shift left, subtract divisor if it fits, shift in the quotient bit
   assign div_shl_c   = {acc_q[2*WIDTH-1:0], 1'b0};
   assign div_trial_c = div_shl_c[2*WIDTH:WIDTH] - {1'b0, b_q};
   assign div_step_c  = (div_shl_c[2*WIDTH:WIDTH] >= {1'b0, b_q})
                        ? {div_trial_c, div_shl_c[WIDTH-1:1], 1'b1}
                        : div_shl_c;

   // Sequencer, datapath and registered outputs
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_MULTU;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  op_q    <= op_e'(Op);
                  a_q     <= OperandA;
                  b_q     <= OperandB;
                  busy_q  <= 1'b1;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               neg_a_q <= is_sgn_c & a_q[WIDTH-1];
               neg_b_q <= is_sgn_c & b_q[WIDTH-1];
               b_q     <= mag_b_c;
               acc_q   <= {{(WIDTH+1){1'b0}}, mag_a_c};
               cnt_q   <= '0;
               if (is_div_c && (b_q == '0)) begin
                  hi_q    <= a_q;
                  lo_q    <= '1;
                  dbz_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               acc_q <= is_div_c ? div_step_c : mul_step_c;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= S_FIXUP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_FIXUP: begin
               if (is_div_c) begin
                  hi_q <= rem_fix_c;
                  lo_q <= quo_fix_c;
               end else begin
                  hi_q <= prod_fix_c[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix_c[WIDTH-1:0];
               end
               dbz_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign HiOut     = hi_q;
   assign LoOut     = lo_q;
   assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, arithmetic results, latency and handshake.
module tb_mul_div_unit;

   localparam int unsigned W = 32;

   logic         CLK      = 1'b0;
   logic         RST_n    = 1'b0;
   logic         Start    = 1'b0;
   logic [1:0]   Op       = 2'b00;
   logic [W-1:0] OperandA = '0;
   logic [W-1:0] OperandB = '0;
   logic         Busy;
   logic         Done;
   logic [W-1:0] HiOut;
   logic [W-1:0] LoOut;
   logic         DivByZero;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   mul_div_unit #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .Busy      (Busy),
      .Done      (Done),
      .HiOut     (HiOut),
      .LoOut     (LoOut),
      .DivByZero (DivByZero)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Issue one op, wait (bounded) for Done, capture outputs in the Done cycle, return in the following IDLE cycle
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic dbz);
      Start = 1'b1; Op = op; OperandA = a; OperandB = b;
      step();
      Start = 1'b0;
      lat = 1;
      while (Done !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      hi  = HiOut;
      lo  = LoOut;
      dbz = DivByZero;
      step();
   endtask

   task automatic test_reset();
      logic [2*W+2:0] obs;
      RST_n = 1'b0;
      step(); step();
      obs = {Busy, Done, DivByZero, HiOut, LoOut};
      n_cmp++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL reset_state got %h want 0", obs);
      end
      #2 RST_n = 1'b1;
      step();
   endtask

   task automatic test_multu_full();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, hi, lo, dbz);
      n_cmp++; if (lat !== 35) begin n_bad++; $display("FAIL multu_latency got %0d want 35", lat); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", lo); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_after got %b want 0", Busy); end
   endtask

   task automatic test_reset_mid_op();
      logic [2*W+2:0] obs;
      bit seen_done = 0;
      Start = 1'b1; Op = 2'b00; OperandA = 32'hFFFF_FFFF; OperandB = 32'hFFFF_FFFF;
      step();
      Start = 1'b0;
      n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL midop_busy got %b want 1", Busy); end
      for (int i = 0; i < 9; i++) step();
      RST_n = 1'b0;
      #1;
      obs = {Busy, Done, DivByZero, HiOut, LoOut};
      n_cmp++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL midop_async_reset got %h want 0", obs);
      end
      #2 RST_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (Done === 1'b1 || Busy === 1'b1) seen_done = 1;
      end
      n_cmp++;
      if (seen_done) begin n_bad++; $display("FAIL midop_discarded got activity=1 want 0"); end
   endtask

   task automatic test_mult();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      run_op(2'b01, 32'hFFFF_FFF9, 32'd6, lat, hi, lo, dbz);
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFD6) begin n_bad++; $display("FAIL mult_neg_lo got %h want ffffffd6", lo); end
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, hi, lo, dbz);
      n_cmp++; if (hi !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi got %h want 40000000", hi); end
      n_cmp++; if (lo !== 32'h0000_0000) begin n_bad++; $display("FAIL mult_min_lo got %h want 00000000", lo); end
   endtask

   task automatic test_div();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, hi, lo, dbz);
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
      n_cmp++; if (lat !== 35) begin n_bad++; $display("FAIL div_latency got %0d want 35", lat); end
      run_op(2'b10, 32'd100, 32'd7, lat, hi, lo, dbz);
      n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", lo); end
      n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", hi); end
   endtask

   task automatic test_overflow();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, dbz);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_lo got %h want 80000000", lo); end
      n_cmp++; if (hi !== 32'h0000_0000) begin n_bad++; $display("FAIL ovf_hi got %h want 00000000", hi); end
      n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL ovf_flag got %b want 0", dbz); end
   endtask

   task automatic test_div_zero();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      run_op(2'b10, 32'd5, 32'd0, lat, hi, lo, dbz);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dbz_latency got %0d want 2", lat); end
      n_cmp++; if (dbz !== 1'b1) begin n_bad++; $display("FAIL dbz_flag got %b want 1", dbz); end
      n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL dbz_hi got %h want 00000005", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
      n_cmp++; if (DivByZero !== 1'b1) begin n_bad++; $display("FAIL dbz_hold got %b want 1", DivByZero); end
      run_op(2'b00, 32'd3, 32'd4, lat, hi, lo, dbz);
      n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL dbz_cleared got %b want 0", dbz); end
      n_cmp++; if (lo !== 32'd12) begin n_bad++; $display("FAIL dbz_next_lo got %h want 0000000c", lo); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL dbz_next_hi got %h want 00000000", hi); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [W-1:0] hi, lo; logic dbz;
      // Start retriggered mid-op with different operands must be ignored
      Start = 1'b1; Op = 2'b00; OperandA = 32'd10; OperandB = 32'd20;
      step();
      Start = 1'b0;
      lat = 1;
      while (Done !== 1'b1 && lat < 100) begin
         if (lat == 5) begin
            Start = 1'b1; Op = 2'b10; OperandA = 32'd999; OperandB = 32'd3;
         end else begin
            Start = 1'b0;
         end
         step();
         lat++;
      end
      Start = 1'b0;
      n_cmp++; if (lat !== 35) begin n_bad++; $display("FAIL ignore_latency got %0d want 35", lat); end
      n_cmp++; if (LoOut !== 32'd200) begin n_bad++; $display("FAIL ignore_lo got %h want 000000c8", LoOut); end
      n_cmp++; if (HiOut !== 32'd0) begin n_bad++; $display("FAIL ignore_hi got %h want 00000000", HiOut); end
      step();
      n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", Done); end
      n_cmp++; if (LoOut !== 32'd200) begin n_bad++; $display("FAIL result_hold got %h want 000000c8", LoOut); end
      // Start in the cycle right after Done
      run_op(2'b01, 32'hFFFF_FFF9, 32'd6, lat, hi, lo, dbz);
      n_cmp++; if (lat !== 35) begin n_bad++; $display("FAIL b2b_latency got %0d want 35", lat); end
      n_cmp++; if (lo !== 32'hFFFF_FFD6) begin n_bad++; $display("FAIL b2b_lo got %h want ffffffd6", lo); end
   endtask

   initial begin
      test_reset();
      test_multu_full();
      test_reset_mid_op();
      test_mult();
      test_div();
      test_overflow();
      test_div_zero();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
